reorder_buffer: RTL and testbench

- Circular in-order commit queue for the Tomasulo core.
- Allocates one entry per dispatched instruction and captures results from the CDB.
- Retires the head entry to the register file, signals store commit to the LSB, and raises flush on branch/JALR redirect.
- Drives the register-file commit port (rob_rf_*) and the entry-ID handshake (rob_head_id / rob_tail_id).

---
 rtl/reorder_buffer.sv | 242 ++++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit queue with CDB capture and redirect.
// Optional macro ROB_QUERY_EN adds two combinational ready/value lookup ports.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef REG_CNT_WIDTH
`define REG_CNT_WIDTH 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

module reorder_buffer #(
  parameter int SIZE_WIDTH = `ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      stall,
  input  logic                      dec_ready,
  input  logic [`INST_OP_WIDTH-1:0] dec_op,
  input  logic [`REG_CNT_WIDTH-1:0] dec_rd,
  input  logic [`XLEN-1:0]          dec_pc,
  input  logic                      dec_pred_jump,
  input  logic                      cdb_ready,
  input  logic [SIZE_WIDTH-1:0]     cdb_id,
  input  logic [`XLEN-1:0]          cdb_val,
  input  logic                      cdb_jump,
  input  logic [`XLEN-1:0]          cdb_target,
`ifdef ROB_QUERY_EN
  input  logic [SIZE_WIDTH-1:0]     q_id1,
  input  logic [SIZE_WIDTH-1:0]     q_id2,
  output logic                      q_ready1,
  output logic [`XLEN-1:0]          q_val1,
  output logic                      q_ready2,
  output logic [`XLEN-1:0]          q_val2,
`endif
  output logic                      rob_full,
  output logic                      rob_rf_enable,
  output logic [`REG_CNT_WIDTH-1:0] rob_rf_rd,
  output logic [`XLEN-1:0]          rob_rf_val,
  output logic [SIZE_WIDTH-1:0]     rob_head_id,
  output logic [SIZE_WIDTH-1:0]     rob_tail_id,
  output logic                      rob_store_commit,
  output logic                      flush,
  output logic [`XLEN-1:0]          flush_pc
);

  localparam int SIZE = 1 << SIZE_WIDTH;
  localparam logic [`INST_OP_WIDTH-1:0] OP_JALR = 4;
  localparam logic [`INST_OP_WIDTH-1:0] OP_BEQ  = 5;
  localparam logic [`INST_OP_WIDTH-1:0] OP_BNE  = 6;
  localparam logic [`INST_OP_WIDTH-1:0] OP_BLT  = 7;
  localparam logic [`INST_OP_WIDTH-1:0] OP_BGE  = 8;
  localparam logic [`INST_OP_WIDTH-1:0] OP_BLTU = 9;
  localparam logic [`INST_OP_WIDTH-1:0] OP_BGEU = 10;
  localparam logic [`INST_OP_WIDTH-1:0] OP_SB   = 16;
  localparam logic [`INST_OP_WIDTH-1:0] OP_SH   = 17;
  localparam logic [`INST_OP_WIDTH-1:0] OP_SW   = 18;

  typedef logic [SIZE_WIDTH-1:0] id_t;

  logic [SIZE-1:0] busy_q, busy_d;
  logic [SIZE-1:0] rdy_q, rdy_d;
  logic [SIZE-1:0] pred_q, pred_d;
  logic [SIZE-1:0] jump_q, jump_d;
  logic [`INST_OP_WIDTH-1:0] op_q [SIZE];
  logic [`INST_OP_WIDTH-1:0] op_d [SIZE];
  logic [`REG_CNT_WIDTH-1:0] rd_q [SIZE];
  logic [`REG_CNT_WIDTH-1:0] rd_d [SIZE];
  logic [`XLEN-1:0] pc_q [SIZE];
  logic [`XLEN-1:0] pc_d [SIZE];
  logic [`XLEN-1:0] val_q [SIZE];
  logic [`XLEN-1:0] val_d [SIZE];
  logic [`XLEN-1:0] tgt_q [SIZE];
  logic [`XLEN-1:0] tgt_d [SIZE];

  id_t head_q, head_d;
  id_t tail_q, tail_d;
  logic [SIZE_WIDTH:0] cnt_q, cnt_d;

  logic rf_en_q, rf_en_d;
  logic [`REG_CNT_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [`XLEN-1:0] rf_val_q, rf_val_d;
  logic sc_q, sc_d;
  logic flush_q, flush_d;
  logic [`XLEN-1:0] fpc_q, fpc_d;

  logic alloc, commit, cdb_hit, redirect;
  logic h_branch, h_store, h_jalr;
  id_t h;

  function automatic logic is_store(logic [`INST_OP_WIDTH-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  assign rob_full = cnt_q == (SIZE_WIDTH+1)'(SIZE);

  always_comb begin
    h = head_q;
    h_branch = op_q[h] inside
      {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    h_store = is_store(op_q[h]);
    h_jalr = op_q[h] == OP_JALR;
    cdb_hit = cdb_ready && !flush_q && busy_q[cdb_id];
    alloc = dec_ready && !stall && !flush_q && !rob_full;
    // A result landing on the head this edge delays its commit by one edge.
    commit = busy_q[h] && rdy_q[h] && !(cdb_hit && cdb_id == h);
    redirect = commit &&
      (h_jalr || (h_branch && jump_q[h] != pred_q[h]));

    busy_d = busy_q;
    rdy_d = rdy_q;
    pred_d = pred_q;
    jump_d = jump_q;
    op_d = op_q;
    rd_d = rd_q;
    pc_d = pc_q;
    val_d = val_q;
    tgt_d = tgt_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d = cnt_q + (SIZE_WIDTH+1)'(alloc)
                  - (SIZE_WIDTH+1)'(commit);
    rf_en_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_val_d = rf_val_q;
    sc_d = 1'b0;
    flush_d = 1'b0;
    fpc_d = fpc_q;

    if (alloc) begin
      busy_d[tail_q] = 1'b1;
      rdy_d[tail_q] = is_store(dec_op);
      op_d[tail_q] = dec_op;
      rd_d[tail_q] = dec_rd;
      pc_d[tail_q] = dec_pc;
      pred_d[tail_q] = dec_pred_jump;
      tail_d = tail_q + id_t'(1);
    end

    if (cdb_hit) begin
      rdy_d[cdb_id] = 1'b1;
      val_d[cdb_id] = cdb_val;
      jump_d[cdb_id] = cdb_jump;
      tgt_d[cdb_id] = cdb_target;
    end

    if (commit) begin
      busy_d[h] = 1'b0;
      head_d = h + id_t'(1);
      sc_d = h_store;
      rf_en_d = !h_branch && !h_store;
      if (rf_en_d) begin
        rf_rd_d = rd_q[h];
        rf_val_d = val_q[h];
      end
    end

    if (redirect) begin
      flush_d = 1'b1;
      fpc_d = (h_jalr || jump_q[h]) ? tgt_q[h]
                                    : pc_q[h] + `XLEN'(4);
      head_d = '0;
      tail_d = '0;
      cnt_d = '0;
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      rdy_q <= '0;
      pred_q <= '0;
      jump_q <= '0;
      op_q <= '{default: '0};
      rd_q <= '{default: '0};
      pc_q <= '{default: '0};
      val_q <= '{default: '0};
      tgt_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      rf_en_q <= 1'b0;
      rf_rd_q <= '0;
      rf_val_q <= '0;
      sc_q <= 1'b0;
      flush_q <= 1'b0;
      fpc_q <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      rdy_q <= rdy_d;
      pred_q <= pred_d;
      jump_q <= jump_d;
      op_q <= op_d;
      rd_q <= rd_d;
      pc_q <= pc_d;
      val_q <= val_d;
      tgt_q <= tgt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      rf_en_q <= rf_en_d;
      rf_rd_q <= rf_rd_d;
      rf_val_q <= rf_val_d;
      sc_q <= sc_d;
      flush_q <= flush_d;
      fpc_q <= fpc_d;
    end
  end

  assign rob_rf_enable = rf_en_q;
  assign rob_rf_rd = rf_rd_q;
  assign rob_rf_val = rf_val_q;
  assign rob_head_id = head_q;
  assign rob_tail_id = tail_q;
  assign rob_store_commit = sc_q;
  assign flush = flush_q;
  assign flush_pc = fpc_q;

`ifdef ROB_QUERY_EN
  always_comb begin
    q_ready1 = rdy_q[q_id1];
    q_val1 = val_q[q_id1];
    q_ready2 = rdy_q[q_id2];
    q_val2 = val_q[q_id2];
    if (cdb_ready && cdb_id == q_id1) begin
      q_ready1 = 1'b1;
      q_val1 = cdb_val;
    end
    if (cdb_ready && cdb_id == q_id2) begin
      q_ready2 = 1'b1;
      q_val2 = cdb_val;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed table, corner sequences and random traffic
// against a queue-based model of the reorder buffer.
module tb_reorder_buffer;

  localparam int OP_LUI = 1, OP_JALR = 4, OP_BEQ = 5, OP_BNE = 6;
  localparam int OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10;
  localparam int OP_LW = 13, OP_SB = 16, OP_SH = 17, OP_SW = 18;
  localparam int OP_ADDI = 19, OP_ADD = 28;

  logic clk = 1'b0;
  logic rst, rdy, stall, dec_ready, dec_pred_jump;
  logic [5:0] dec_op;
  logic [4:0] dec_rd;
  logic [31:0] dec_pc;
  logic cdb_ready, cdb_jump;
  logic [2:0] cdb_id;
  logic [31:0] cdb_val, cdb_target;
  logic rob_full, rob_rf_enable, rob_store_commit, flush;
  logic [4:0] rob_rf_rd;
  logic [31:0] rob_rf_val, flush_pc;
  logic [2:0] rob_head_id, rob_tail_id;
`ifdef ROB_QUERY_EN
  logic [2:0] q_id1, q_id2;
  logic q_ready1, q_ready2;
  logic [31:0] q_val1, q_val2;
`endif

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
    .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd),
    .dec_pc(dec_pc), .dec_pred_jump(dec_pred_jump),
    .cdb_ready(cdb_ready), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_target(cdb_target),
`ifdef ROB_QUERY_EN
    .q_id1(q_id1), .q_id2(q_id2),
    .q_ready1(q_ready1), .q_val1(q_val1),
    .q_ready2(q_ready2), .q_val2(q_val2),
`endif
    .rob_full(rob_full), .rob_rf_enable(rob_rf_enable),
    .rob_rf_rd(rob_rf_rd), .rob_rf_val(rob_rf_val),
    .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
    .rob_store_commit(rob_store_commit),
    .flush(flush), .flush_pc(flush_pc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id; int op; int rd; int pc;
    bit pred; bit ready; bit jump; int val; int tgt;
  } ent_t;

  ent_t mq[$];
  int m_tail = 0;
  bit m_flush = 0;
  bit e_en = 0, e_sc = 0, e_fl = 0;
  int e_rd = 0, e_val = 0, e_fpc = 0;

  function automatic bit op_is_branch(int op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic bit op_is_store(int op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  task automatic model_step();
    bit commit, hit;
    ent_t n;
    if (rst) begin
      mq.delete();
      m_tail = 0; m_flush = 0;
      e_en = 0; e_sc = 0; e_fl = 0;
      e_rd = 0; e_val = 0; e_fpc = 0;
      return;
    end
    if (!rdy) return;
    e_en = 0; e_sc = 0; e_fl = 0;
    hit = cdb_ready && !m_flush;
    commit = mq.size() > 0 && mq[0].ready &&
             !(hit && int'(cdb_id) == mq[0].id);
    if (commit) begin
      e_sc = op_is_store(mq[0].op);
      e_en = !op_is_branch(mq[0].op) && !e_sc;
      e_rd = mq[0].rd;
      e_val = mq[0].val;
      if (mq[0].op == OP_JALR) begin
        e_fl = 1; e_fpc = mq[0].tgt;
      end else if (op_is_branch(mq[0].op) && mq[0].jump != mq[0].pred) begin
        e_fl = 1;
        e_fpc = mq[0].jump ? mq[0].tgt : mq[0].pc + 4;
      end
    end
    if (hit)
      foreach (mq[i])
        if (mq[i].id == int'(cdb_id)) begin
          mq[i].ready = 1; mq[i].val = int'(cdb_val);
          mq[i].jump = cdb_jump; mq[i].tgt = int'(cdb_target);
        end
    if (dec_ready && !stall && !m_flush && mq.size() < 8) begin
      n.id = m_tail; n.op = int'(dec_op); n.rd = int'(dec_rd);
      n.pc = int'(dec_pc); n.pred = dec_pred_jump;
      n.ready = op_is_store(int'(dec_op));
      n.jump = 0; n.val = 0; n.tgt = 0;
      mq.push_back(n);
      m_tail = (m_tail + 1) % 8;
    end
    if (commit) void'(mq.pop_front());
    if (e_fl) begin
      mq.delete();
      m_tail = 0;
    end
    m_flush = e_fl;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("full", 32'(rob_full), 32'(mq.size() == 8));
    chk("head", 32'(rob_head_id), (m_tail - mq.size()) & 7);
    chk("tail", 32'(rob_tail_id), m_tail);
    chk("rf_en", 32'(rob_rf_enable), 32'(e_en));
    chk("store_commit", 32'(rob_store_commit), 32'(e_sc));
    chk("flush", 32'(flush), 32'(e_fl));
    if (e_en) begin
      chk("rf_rd", 32'(rob_rf_rd), e_rd);
      chk("rf_val", rob_rf_val, e_val);
    end
    if (e_fl) chk("flush_pc", flush_pc, e_fpc);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; stall = 0;
    dec_ready = 0; dec_op = '0; dec_rd = '0; dec_pc = '0; dec_pred_jump = 0;
    cdb_ready = 0; cdb_id = '0; cdb_val = '0; cdb_jump = 0; cdb_target = '0;
  endtask

  task automatic set_alloc(int op, int rd, int pc, bit pred);
    dec_ready = 1; dec_op = op[5:0]; dec_rd = rd[4:0];
    dec_pc = pc; dec_pred_jump = pred;
  endtask

  task automatic set_cdb(int id, int val, bit j, int t);
    cdb_ready = 1; cdb_id = id[2:0]; cdb_val = val;
    cdb_jump = j; cdb_target = t;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); idle();
  endtask

  typedef struct {
    int rst; int dv; int op; int rd; int pc; int pred;
    int cv; int cid; int cval; int cj; int ct;
    int e_en; int e_rd; int e_val; int e_fl; int e_fpc; int e_sc;
    int e_h; int e_t; int e_full;
  } vec_t;

  vec_t tv[$];
  int ops[14] = '{OP_LUI, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU,
                  OP_BGEU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADDI, OP_ADD};

  initial begin
    idle();
    tv.push_back('{1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0});
    tv.push_back('{0,1,OP_ADDI,5,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 1,0,'h2A,0,0, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 1,5,'h2A,0,0,0, 1,1,0});
    tv.push_back('{1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0});
    tv.push_back('{0,1,OP_BEQ,0,'h100,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 1,0,0,1,'h80, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,'h80,0, 0,0,0});
    tv.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0});
    tv.push_back('{0,1,OP_JALR,1,'h200,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 1,0,'h204,0,'h300, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 1,1,'h204,1,'h300,0, 0,0,0});
    tv.push_back('{0,1,OP_ADDI,3,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0});
    tv.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0});
    tv.push_back('{0,1,OP_BNE,0,'h40,1, 0,0,0,0,0, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0,0, 0,1,0});
    tv.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,'h44,0, 0,0,0});

    foreach (tv[i]) begin
      idle();
      rst = tv[i].rst[0];
      if (tv[i].dv != 0) set_alloc(tv[i].op, tv[i].rd, tv[i].pc, tv[i].pred[0]);
      if (tv[i].cv != 0) set_cdb(tv[i].cid, tv[i].cval, tv[i].cj[0], tv[i].ct);
      cyc();
      chk($sformatf("v%0d_en", i), 32'(rob_rf_enable), tv[i].e_en);
      chk($sformatf("v%0d_flush", i), 32'(flush), tv[i].e_fl);
      chk($sformatf("v%0d_sc", i), 32'(rob_store_commit), tv[i].e_sc);
      chk($sformatf("v%0d_head", i), 32'(rob_head_id), tv[i].e_h);
      chk($sformatf("v%0d_tail", i), 32'(rob_tail_id), tv[i].e_t);
      chk($sformatf("v%0d_full", i), 32'(rob_full), tv[i].e_full);
      if (tv[i].e_en != 0) begin
        chk($sformatf("v%0d_rd", i), 32'(rob_rf_rd), tv[i].e_rd);
        chk($sformatf("v%0d_val", i), rob_rf_val, tv[i].e_val);
      end
      if (tv[i].e_fl != 0)
        chk($sformatf("v%0d_fpc", i), flush_pc, tv[i].e_fpc);
    end

    // fill to full, then a dropped ninth allocation
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle(); set_alloc(OP_ADDI, k + 1, k * 4, 0); cyc();
    end
    chk("fill_full", 32'(rob_full), 1);
    chk("fill_tail", 32'(rob_tail_id), 0);
    idle(); set_alloc(OP_ADDI, 9, 'h40, 0); cyc();
    chk("drop_tail", 32'(rob_tail_id), 0);
    chk("drop_full", 32'(rob_full), 1);
    chk("drop_head", 32'(rob_head_id), 0);

    // store retires before the later ALU op
    do_reset();
    set_alloc(OP_SW, 0, 'h10, 0); cyc();
    idle(); set_alloc(OP_ADD, 7, 'h14, 0); cyc();
    chk("sw_sc", 32'(rob_store_commit), 1);
    chk("sw_en", 32'(rob_rf_enable), 0);
    chk("sw_head", 32'(rob_head_id), 1);
    idle(); set_cdb(1, 'h99, 0, 0); cyc();
    chk("add_sc_clr", 32'(rob_store_commit), 0);
    idle(); cyc();
    chk("add_en", 32'(rob_rf_enable), 1);
    chk("add_rd", 32'(rob_rf_rd), 7);
    chk("add_val", rob_rf_val, 'h99);
    chk("add_head", 32'(rob_head_id), 2);

    // allocate and commit on the same edge with count 3
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle(); set_alloc(OP_ADDI, k + 1, 0, 0); cyc();
    end
    idle(); set_cdb(0, 'h11, 0, 0); cyc();
    idle(); set_alloc(OP_ADDI, 4, 0, 0); cyc();
    chk("same_en", 32'(rob_rf_enable), 1);
    chk("same_head", 32'(rob_head_id), 1);
    chk("same_tail", 32'(rob_tail_id), 4);
    for (int k = 0; k < 5; k++) begin
      idle(); set_alloc(OP_ADDI, 5, 0, 0); cyc();
      chk($sformatf("cnt_full%0d", k), 32'(rob_full), 32'(k == 4));
    end

    // rdy low holds, CDB hit on head delays commit, outputs hold
    do_reset();
    set_alloc(OP_ADDI, 9, 0, 0); cyc();
    idle(); rdy = 0; set_cdb(0, 'h55, 0, 0); cyc();
    idle(); set_cdb(0, 1, 0, 0); cyc();
    chk("hit_pre", 32'(rob_rf_enable), 0);
    idle(); set_cdb(0, 2, 0, 0); cyc();
    chk("hit_block", 32'(rob_rf_enable), 0);
    idle(); cyc();
    chk("hit_commit", 32'(rob_rf_enable), 1);
    chk("hit_val", rob_rf_val, 2);
    idle(); rdy = 0; cyc();
    chk("hold_en", 32'(rob_rf_enable), 1);
    chk("hold_head", 32'(rob_head_id), 1);

`ifdef ROB_QUERY_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle(); set_alloc(OP_ADDI, 1, 0, 0); cyc();
    end
    idle(); q_id1 = 2; q_id2 = 0; set_cdb(2, 7, 0, 0);
    #1;
    chk("q_ready1", 32'(q_ready1), 1);
    chk("q_val1", q_val1, 7);
    chk("q_ready2", 32'(q_ready2), 0);
    cyc();
`endif

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) < 6)
        set_alloc(ops[$urandom_range(0, 13)], $urandom_range(0, 31),
                  int'($urandom & 32'hFFFF_FFFC), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          set_cdb(mq[$urandom_range(0, mq.size() - 1)].id, int'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom & 32'hFFFF_FFFC));
        else
          set_cdb($urandom_range(0, 7), int'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom));
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
